// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fetch
//  Description : Operand-fetch pipeline stage between decode and execute.
//                Drives the register file read indices straight from the
//                decoded source fields and captures the returned operands,
//                together with the instruction payload, into an output
//                pipeline register.
//                A per-register scoreboard of pending writes stalls decode
//                on read-after-write hazards until the writer retires.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature (compile-time macro):
//    WB_BYPASS_EN - forward wb_data into a source operand whose writer is
//                   retiring in the current cycle. This removes one stall
//                   cycle from each RAW hazard. Undefined by default.
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   clock, all state updates on the rising edge
//    aresetn      in   synchronous active-low reset
//    in_valid     in   decode presents an instruction
//    in_ready     out  stage accepts this cycle (combinational)
//    in_pc        in   instruction PC
//    in_rs1/rs2   in   source register indices
//    in_rd        in   destination register index
//    in_rd_wen    in   instruction writes in_rd
//    in_ctrl      in   opaque decoded control bundle
//    rd_reg_a/b   out  register file read indices (= in_rs1/in_rs2)
//    rd_data_a/b  in   register file read data
//    wb_en        in   writeback retires a write this cycle
//    wb_reg       in   register being retired
//    wb_data      in   value being retired
//    out_valid    out  execute payload valid
//    out_ready    in   execute accepts payload
//    out_pc, out_rd, out_rd_wen, out_ctrl  out  registered payload
//    out_op_a/b   out  registered operands
//    sb_busy      out  scoreboard busy bits (debug)
// ============================================================================
module operand_fetch #(
    parameter int REG_COUNT = 32,
    parameter int REG_W     = 32,
    parameter int REG_IDX_W = $clog2(REG_COUNT),
    parameter int PC_W      = 32,
    parameter int CTRL_W    = 16
) (
    input  logic                 clk,
    input  logic                 aresetn,
    // decode side
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [REG_IDX_W-1:0] in_rs1,
    input  logic [REG_IDX_W-1:0] in_rs2,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic                 in_rd_wen,
    input  logic [CTRL_W-1:0]    in_ctrl,
    // register file read
    output logic [REG_IDX_W-1:0] rd_reg_a,
    output logic [REG_IDX_W-1:0] rd_reg_b,
    input  logic [REG_W-1:0]     rd_data_a,
    input  logic [REG_W-1:0]     rd_data_b,
    // writeback
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_reg,
    input  logic [REG_W-1:0]     wb_data,
    // execute side
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic                 out_rd_wen,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [REG_W-1:0]     out_op_a,
    output logic [REG_W-1:0]     out_op_b,
    // debug
    output logic [REG_COUNT-1:0] sb_busy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                 out_valid_q,  out_valid_d;
    logic [PC_W-1:0]      out_pc_q,     out_pc_d;
    logic [REG_IDX_W-1:0] out_rd_q,     out_rd_d;
    logic                 out_rd_wen_q, out_rd_wen_d;
    logic [CTRL_W-1:0]    out_ctrl_q,   out_ctrl_d;
    logic [REG_W-1:0]     out_op_a_q,   out_op_a_d;
    logic [REG_W-1:0]     out_op_b_q,   out_op_b_d;
    logic [REG_COUNT-1:0] sb_busy_q,    sb_busy_d;

    logic                 w_byp1;
    logic                 w_byp2;
    logic [REG_W-1:0]     w_op_a;
    logic [REG_W-1:0]     w_op_b;
    logic                 w_haz1;
    logic                 w_haz2;
    logic                 w_in_ready;
    logic                 w_accept;

    // ------------------------------------------------------------------
    // Writeback bypass
    // ------------------------------------------------------------------
`ifdef WB_BYPASS_EN
    // A source whose writer retires this cycle takes the retiring value
    // directly; the register file would only show it after this edge.
    assign w_byp1 = wb_en && (wb_reg == in_rs1) && (in_rs1 != '0);
    assign w_byp2 = wb_en && (wb_reg == in_rs2) && (in_rs2 != '0);
    assign w_op_a = w_byp1 ? wb_data : rd_data_a;
    assign w_op_b = w_byp2 ? wb_data : rd_data_b;
`else
    logic w_unused_wb_data;
    assign w_unused_wb_data = ^wb_data;
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
    assign w_op_a = rd_data_a;
    assign w_op_b = rd_data_b;
`endif

    // ------------------------------------------------------------------
    // Hazard detection and handshake
    // ------------------------------------------------------------------
    // x0 never carries a pending write, so it can never be hazardous.
    assign w_haz1 = (in_rs1 != '0) && sb_busy_q[in_rs1] && !w_byp1;
    assign w_haz2 = (in_rs2 != '0) && sb_busy_q[in_rs2] && !w_byp2;

    // Does not depend on in_valid, so decode may use it as a look-ahead.
    assign w_in_ready = aresetn && (!out_valid_q || out_ready) && !w_haz1 && !w_haz2;
    assign w_accept   = in_valid && w_in_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_rd_d     = out_rd_q;
        out_rd_wen_d = out_rd_wen_q;
        out_ctrl_d   = out_ctrl_q;
        out_op_a_d   = out_op_a_q;
        out_op_b_d   = out_op_b_q;
        sb_busy_d    = sb_busy_q;

        if (w_accept) begin
            out_valid_d  = 1'b1;
            out_pc_d     = in_pc;
            out_rd_d     = in_rd;
            out_rd_wen_d = in_rd_wen;
            out_ctrl_d   = in_ctrl;
            out_op_a_d   = w_op_a;
            out_op_b_d   = w_op_b;
        end else if (out_ready) begin
            // Payload registers keep their last value; only valid drops.
            out_valid_d  = 1'b0;
        end

        // Clear first so that a newer writer issued in the same cycle
        // leaves its destination marked pending.
        if (wb_en) begin
            sb_busy_d[wb_reg] = 1'b0;
        end
        if (w_accept && in_rd_wen && (in_rd != '0)) begin
            sb_busy_d[in_rd] = 1'b1;
        end
        sb_busy_d[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_rd_q     <= '0;
            out_rd_wen_q <= 1'b0;
            out_ctrl_q   <= '0;
            out_op_a_q   <= '0;
            out_op_b_q   <= '0;
            sb_busy_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_rd_q     <= out_rd_d;
            out_rd_wen_q <= out_rd_wen_d;
            out_ctrl_q   <= out_ctrl_d;
            out_op_a_q   <= out_op_a_d;
            out_op_b_q   <= out_op_b_d;
            sb_busy_q    <= sb_busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready   = w_in_ready;
    assign rd_reg_a   = in_rs1;
    assign rd_reg_b   = in_rs2;
    assign out_valid  = out_valid_q;
    assign out_pc     = out_pc_q;
    assign out_rd     = out_rd_q;
    assign out_rd_wen = out_rd_wen_q;
    assign out_ctrl   = out_ctrl_q;
    assign out_op_a   = out_op_a_q;
    assign out_op_b   = out_op_b_q;
    assign sb_busy    = sb_busy_q;

endmodule
`default_nettype wire
